// File: rtl/uvma_apb_req_arbiter.sv
// Round-robin arbiter sharing one APB master port among NUM_REQ requesters.
// Sequences SETUP/ACCESS, routes responses back, aborts stalled transfers.
module uvma_apb_req_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ-1:0]           req_write,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  input  logic [NUM_REQ*DATA_WIDTH/8-1:0] req_strb,
  input  logic [NUM_REQ*3-1:0]         req_prot,
  output logic [NUM_REQ-1:0]           rsp_valid,
  output logic [DATA_WIDTH-1:0]        rsp_rdata,
  output logic                         rsp_err,
  output logic                         timeout,
  output logic                         psel,
  output logic                         penable,
  output logic                         pwrite,
  output logic [ADDR_WIDTH-1:0]        paddr,
  output logic [DATA_WIDTH-1:0]        pwdata,
  output logic [DATA_WIDTH/8-1:0]      pstrb,
  output logic [2:0]                   pprot,
  input  logic                         pready,
  input  logic                         pslverr,
  input  logic [DATA_WIDTH-1:0]        prdata
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int SW = DATA_WIDTH / 8;
  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam bit TO_EN = (TIMEOUT_CYCLES > 0);
  localparam logic [CW-1:0] CNT_LAST =
    CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } state_t;

  state_t                 state_q, state_d;
  logic [IW-1:0]          last_q, last_d;
  logic [IW-1:0]          owner_q, owner_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   psel_q, psel_d;
  logic                   penable_q, penable_d;
  logic                   pwrite_q, pwrite_d;
  logic [ADDR_WIDTH-1:0]  paddr_q, paddr_d;
  logic [DATA_WIDTH-1:0]  pwdata_q, pwdata_d;
  logic [SW-1:0]          pstrb_q, pstrb_d;
  logic [2:0]             pprot_q, pprot_d;
  logic [NUM_REQ-1:0]     rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0]  rsp_rdata_q, rsp_rdata_d;
  logic                   rsp_err_q, rsp_err_d;
  logic                   timeout_q, timeout_d;

  logic                   arb_en;
  logic                   hit;
  logic                   grant;
  logic [IW-1:0]          winner;
  logic [IW-1:0]          cand;
  int                     idx;
  logic [ADDR_WIDTH-1:0]  sel_addr;
  logic                   sel_write;
  logic [DATA_WIDTH-1:0]  sel_wdata;
  logic [SW-1:0]          sel_strb;
  logic [2:0]             sel_prot;

  // Scan from the requester after the last winner, wrapping around
  always_comb begin
    arb_en = (state_q == IDLE) || ((state_q == ACCESS) && pready);
    hit    = 1'b0;
    winner = '0;
    cand   = '0;
    idx    = 0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = int'(last_q) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      cand = IW'(idx);
      if (!hit && req_valid[cand]) begin
        hit    = 1'b1;
        winner = cand;
      end
    end
    grant = hit && arb_en;
  end

  always_comb begin
    sel_addr  = '0;
    sel_write = 1'b0;
    sel_wdata = '0;
    sel_strb  = '0;
    sel_prot  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (winner == IW'(i)) begin
        sel_addr  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_write = req_write[i];
        sel_wdata = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
        sel_strb  = req_strb[i*SW +: SW];
        sel_prot  = req_prot[i*3 +: 3];
      end
    end
  end

  assign req_ready = grant ? (NUM_REQ'(1) << winner) : '0;

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    owner_d     = owner_q;
    cnt_d       = cnt_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    pstrb_d     = pstrb_q;
    pprot_d     = pprot_q;
    rsp_valid_d = '0;
    rsp_rdata_d = '0;
    rsp_err_d   = 1'b0;
    timeout_d   = 1'b0;
    unique case (state_q)
      IDLE: ;
      SETUP: begin
        state_d = ACCESS;
        cnt_d   = '0;
      end
      ACCESS: begin
        if (pready) begin
          state_d     = IDLE;
          rsp_valid_d = NUM_REQ'(1) << owner_q;
          rsp_rdata_d = pwrite_q ? '0 : prdata;
          rsp_err_d   = pslverr;
        end else if (TO_EN && (cnt_q == CNT_LAST)) begin
          state_d     = IDLE;
          rsp_valid_d = NUM_REQ'(1) << owner_q;
          rsp_err_d   = 1'b1;
          timeout_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // A grant in the completion cycle overrides the return to IDLE
    if (grant) begin
      state_d  = SETUP;
      last_d   = winner;
      owner_d  = winner;
      paddr_d  = sel_addr;
      pwrite_d = sel_write;
      pwdata_d = sel_write ? sel_wdata : '0;
      pstrb_d  = sel_write ? sel_strb : '0;
      pprot_d  = sel_prot;
    end
    psel_d    = (state_d != IDLE);
    penable_d = (state_d == ACCESS);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      last_q      <= IW'(NUM_REQ - 1);
      owner_q     <= '0;
      cnt_q       <= '0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      pstrb_q     <= '0;
      pprot_q     <= '0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      owner_q     <= owner_d;
      cnt_q       <= cnt_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      pstrb_q     <= pstrb_d;
      pprot_q     <= pprot_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      timeout_q   <= timeout_d;
    end
  end

  assign psel      = psel_q;
  assign penable   = penable_q;
  assign pwrite    = pwrite_q;
  assign paddr     = paddr_q;
  assign pwdata    = pwdata_q;
  assign pstrb     = pstrb_q;
  assign pprot     = pprot_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign timeout   = timeout_q;

endmodule

// File: tb/tb_uvma_apb_req_arbiter.sv
// Bench for uvma_apb_req_arbiter: directed scenarios then random traffic,
// checked every cycle against a transaction-level reference model.
module tb_uvma_apb_req_arbiter;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int TO = 16;

  logic            clk = 1'b0;
  logic            reset_n;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*AW-1:0] req_addr;
  logic [N-1:0]    req_write;
  logic [N*DW-1:0] req_wdata;
  logic [N*SW-1:0] req_strb;
  logic [N*3-1:0]  req_prot;
  logic [N-1:0]    rsp_valid;
  logic [DW-1:0]   rsp_rdata;
  logic            rsp_err;
  logic            timeout;
  logic            psel;
  logic            penable;
  logic            pwrite;
  logic [AW-1:0]   paddr;
  logic [DW-1:0]   pwdata;
  logic [SW-1:0]   pstrb;
  logic [2:0]      pprot;
  logic            pready;
  logic            pslverr;
  logic [DW-1:0]   prdata;

  uvma_apb_req_arbiter #(
    .NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_write(req_write),
    .req_wdata(req_wdata), .req_strb(req_strb), .req_prot(req_prot),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .timeout(timeout),
    .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb), .pprot(pprot),
    .pready(pready), .pslverr(pslverr), .prdata(prdata)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // reference model: one in-flight transfer, age in cycles since accept
  bit          busy;
  int          age;
  int          stall;
  int          last_m;
  int          cur;
  logic [AW-1:0] m_addr;
  logic        m_write;
  logic [DW-1:0] m_wdata;
  logic [SW-1:0] m_strb;
  logic [2:0]  m_prot;
  bit          pend;
  int          pend_idx;
  logic [DW-1:0] pend_rdata;
  bit          pend_err;
  bit          pend_to;
  int          acc;
  int          pen_cnt;
  int          to_cnt;
  int          dut_grants[$];

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [N-1:0] oh(input int i);
    logic [N-1:0] one;
    one = 1;
    return one << i;
  endfunction

  task automatic model_reset();
    busy   = 0;
    age    = 0;
    stall  = 0;
    last_m = N - 1;
    cur    = 0;
    pend   = 0;
    acc    = -1;
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] a,
                         input logic w, input logic [DW-1:0] d,
                         input logic [SW-1:0] s, input logic [2:0] p);
    req_addr[i*AW +: AW]  = a;
    req_write[i]          = w;
    req_wdata[i*DW +: DW] = d;
    req_strb[i*SW +: SW]  = s;
    req_prot[i*3 +: 3]    = p;
    req_valid[i]          = 1'b1;
  endtask

  // Called at a negedge with inputs already driven; ends at next negedge
  task automatic step();
    bit           allow;
    int           w;
    int           j;
    logic [N-1:0] exp_rdy;
    #1;
    if (penable === 1'b1) pen_cnt++;
    if (timeout === 1'b1) to_cnt++;
    chk("psel", psel, 64'(busy && age >= 1));
    chk("penable", penable, 64'(busy && age >= 2));
    if (busy && age >= 1) begin
      chk("paddr", paddr, m_addr);
      chk("pwrite", pwrite, m_write);
      chk("pwdata", pwdata, m_wdata);
      chk("pstrb", pstrb, m_strb);
      chk("pprot", pprot, m_prot);
    end
    if (pend) begin
      chk("rsp_valid", rsp_valid, oh(pend_idx));
      chk("rsp_rdata", rsp_rdata, pend_rdata);
      chk("rsp_err", rsp_err, pend_err);
      chk("timeout", timeout, pend_to);
    end else begin
      chk("rsp_idle", rsp_valid, 0);
      chk("timeout_idle", timeout, 0);
    end
    allow = !busy || (age >= 2 && pready === 1'b1);
    w = -1;
    if (allow) begin
      for (int k = 1; k <= N; k++) begin
        j = (last_m + k) % N;
        if (w < 0 && req_valid[j]) w = j;
      end
    end
    exp_rdy = (w >= 0) ? oh(w) : '0;
    chk("req_ready", req_ready, exp_rdy);
    if (req_ready != 0) dut_grants.push_back($clog2(req_ready));
    pend = 0;
    if (busy && age >= 2) begin
      if (pready) begin
        pend       = 1;
        pend_idx   = cur;
        pend_rdata = m_write ? '0 : prdata;
        pend_err   = pslverr;
        pend_to    = 0;
        busy       = 0;
      end else begin
        stall++;
        if (stall == TO) begin
          pend       = 1;
          pend_idx   = cur;
          pend_rdata = '0;
          pend_err   = 1;
          pend_to    = 1;
          busy       = 0;
        end
      end
    end
    if (busy) age++;
    acc = w;
    if (w >= 0) begin
      busy    = 1;
      age     = 1;
      stall   = 0;
      cur     = w;
      last_m  = w;
      m_addr  = req_addr[w*AW +: AW];
      m_write = req_write[w];
      m_wdata = m_write ? req_wdata[w*DW +: DW] : '0;
      m_strb  = m_write ? req_strb[w*SW +: SW] : '0;
      m_prot  = req_prot[w*3 +: 3];
    end
    @(negedge clk);
  endtask

  task automatic run(input int n, input bit hold);
    repeat (n) begin
      step();
      if (acc >= 0 && !hold) req_valid[acc] = 1'b0;
    end
  endtask

  int gb;
  int stall_left;

  initial begin
    reset_n   = 1'b0;
    req_valid = '0;
    req_addr  = '0;
    req_write = '0;
    req_wdata = '0;
    req_strb  = '0;
    req_prot  = '0;
    pready    = 1'b0;
    pslverr   = 1'b0;
    prdata    = '0;
    pen_cnt   = 0;
    to_cnt    = 0;
    model_reset();
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("rst_psel", psel, 0);
    chk("rst_penable", penable, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_paddr", paddr, 0);
    @(negedge clk);

    // single read, zero wait states
    set_req(0, 32'h10, 1'b0, '0, '0, 3'd0);
    pready = 1'b1;
    prdata = 32'hDEADBEEF;
    run(6, 0);
    chk("t1_first_winner", dut_grants[0], 0);

    // two requesters held valid: grants alternate
    gb = dut_grants.size();
    set_req(0, 32'h100, 1'b0, '0, '0, 3'd1);
    set_req(1, 32'h104, 1'b1, 32'hA5A5, 4'hF, 3'd5);
    prdata = 32'h0BAD_F00D;
    run(8, 1);
    req_valid = '0;
    run(4, 0);
    chk("t2_count", 64'(dut_grants.size() >= gb + 4), 1);
    for (int k = 0; k < 4; k++)
      chk("t2_alternate", dut_grants[gb+k], (k % 2 == 0) ? 1 : 0);

    // write with wait states and slave error
    set_req(2, 32'h40, 1'b1, 32'h1234, 4'h3, 3'd2);
    pready  = 1'b0;
    pslverr = 1'b1;
    pen_cnt = 0;
    run(5, 0);
    pready = 1'b1;
    run(1, 0);
    pready  = 1'b0;
    pslverr = 1'b0;
    run(2, 0);
    chk("t3_penable_cycles", pen_cnt, 4);

    // stalled read aborts after TO access cycles, late pready ignored
    set_req(1, 32'h80, 1'b0, '0, '0, 3'd0);
    pen_cnt = 0;
    to_cnt  = 0;
    run(22, 0);
    pready = 1'b1;
    run(2, 0);
    chk("t4_penable_cycles", pen_cnt, TO);
    chk("t4_timeouts", to_cnt, 1);

    // asynchronous reset during ACCESS
    pready = 1'b0;
    set_req(3, 32'hC0, 1'b1, 32'h55, 4'h1, 3'd0);
    run(3, 0);
    chk("t5_in_access", penable, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("t5_psel_async", psel, 0);
    chk("t5_penable_async", penable, 0);
    model_reset();
    @(negedge clk);
    chk("t5_no_rsp", rsp_valid, 0);
    reset_n = 1'b1;
    pready  = 1'b1;
    for (int i = 0; i < N; i++)
      set_req(i, 32'h200 + 32'(i*4), 1'b0, '0, '0, 3'd0);
    gb = dut_grants.size();
    run(16, 0);
    chk("t5_winner_after_reset", dut_grants[gb], 0);

    // all valid with last=2 -> order 3,0,1,2
    set_req(2, 32'h300, 1'b0, '0, '0, 3'd0);
    run(5, 0);
    for (int i = 0; i < N; i++)
      set_req(i, 32'h400 + 32'(i*4), 1'(i % 2), 32'(i), 4'hF, 3'(i));
    gb = dut_grants.size();
    run(16, 0);
    chk("t6_count", 64'(dut_grants.size() >= gb + 4), 1);
    chk("t6_g0", dut_grants[gb], 3);
    chk("t6_g1", dut_grants[gb+1], 0);
    chk("t6_g2", dut_grants[gb+2], 1);
    chk("t6_g3", dut_grants[gb+3], 2);

    // random traffic with occasional long stalls
    stall_left = 0;
    for (int c = 0; c < 3000; c++) begin
      if (stall_left == 0 && $urandom_range(199) == 0) stall_left = 25;
      if (stall_left > 0) begin
        pready = 1'b0;
        stall_left--;
      end else begin
        pready = ($urandom_range(2) != 0);
      end
      pslverr = ($urandom_range(4) == 0);
      prdata  = $urandom;
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i]) begin
          if ($urandom_range(3) == 0)
            set_req(i, $urandom, 1'($urandom), $urandom,
                    SW'($urandom), 3'($urandom));
        end else if ($urandom_range(49) == 0) begin
          req_valid[i] = 1'b0;
        end
      end
      step();
      if (acc >= 0) req_valid[acc] = 1'b0;
    end
    req_valid = '0;
    pready    = 1'b1;
    run(25, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
